press_classifier: RTL and testbench

Consumes the debounced button level produced by the push-button debounce stage and turns it into one-cycle event pulses: press, release, short-press, long-press and auto-repeat. It also keeps a wrapping count of presses for the display and control logic downstream. It sits directly after the debouncer, one instance per button, in the `clk` domain.

---
 rtl/button_pkg.sv | 22 ++
 rtl/edge_detect.sv | 41 ++++
 rtl/press_classifier.sv | 165 ++++++++++++++++
 tb/tb_press_classifier.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// ---------------------------------------------------------------------------
// button_pkg
// Shared definitions for the push-button path: debouncer, press classifier
// and display/control logic.
//   btn_state_t            classifier FSM states
//   DEFAULT_LONG_CYCLES    hold time before a long press (0.5 s at 100 MHz)
//   DEFAULT_REPEAT_CYCLES  auto-repeat period after a long press (0.1 s)
//   DEFAULT_CNT_W          default press counter width
// ---------------------------------------------------------------------------
package button_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } btn_state_t;

    localparam int unsigned DEFAULT_LONG_CYCLES   = 50_000_000;
    localparam int unsigned DEFAULT_REPEAT_CYCLES = 10_000_000;
    localparam int unsigned DEFAULT_CNT_W         = 8;

endpackage

// File: rtl/edge_detect.sv
// ---------------------------------------------------------------------------
// edge_detect
// Registers a synchronous level and flags its rising and falling edges.
// The edge outputs are combinational: they are high while the input holds
// its new value and the register still holds the old one.
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset (register clears to 0)
//   d      in   level to watch, synchronous to clk
//   q      out  d delayed by one cycle
//   rise   out  d & ~q
//   fall   out  ~d & q
// ---------------------------------------------------------------------------
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q    = q_q;
    assign rise = d & ~q_q;
    assign fall = ~d & q_q;

endmodule

// File: rtl/press_classifier.sv
// ---------------------------------------------------------------------------
// press_classifier
// Turns a debounced button level into one-cycle event pulses (press,
// release, short press, long press, auto-repeat) and keeps a wrapping
// press counter.
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   btn_db         in   debounced button level, 1 = pressed
//   count_clr      in   synchronous clear of press_count (beats a press)
//   press_pulse    out  1 cycle on each rising edge of btn_db
//   release_pulse  out  1 cycle on each falling edge of btn_db
//   short_press    out  1 cycle on a release before the long threshold
//   long_press     out  1 cycle when the hold reaches LONG_CYCLES
//   repeat_pulse   out  1 cycle every REPEAT_CYCLES after long_press
//   held           out  registered copy of btn_db
//   press_count    out  presses modulo 2^CNT_W
// All event outputs are registered.
// ---------------------------------------------------------------------------
module press_classifier
    import button_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = DEFAULT_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES,
    parameter int unsigned CNT_W         = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_db,
    input  logic             count_clr,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic             short_press,
    output logic             long_press,
    output logic             repeat_pulse,
    output logic             held,
    output logic [CNT_W-1:0] press_count
);

    localparam int HOLD_W = $clog2(LONG_CYCLES);
    localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);

    // The press edge itself is the first held cycle and hold_cnt starts at 0
    // on the following one, so LONG_CYCLES-2 marks the LONG_CYCLES-th cycle.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 2);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

    logic btn_q;
    logic rise;
    logic fall;

    edge_detect u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_db),
        .q     (btn_q),
        .rise  (rise),
        .fall  (fall)
    );

    btn_state_t        state_q,       state_d;
    logic [HOLD_W-1:0] hold_cnt_q,    hold_cnt_d;
    logic [REP_W-1:0]  rep_cnt_q,     rep_cnt_d;
    logic              press_q,       press_d;
    logic              release_q,     release_d;
    logic              short_q,       short_d;
    logic              long_q,        long_d;
    logic              repeat_q,      repeat_d;
    logic [CNT_W-1:0]  press_count_q, press_count_d;

    // State register and all other flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            hold_cnt_q    <= '0;
            rep_cnt_q     <= '0;
            press_q       <= 1'b0;
            release_q     <= 1'b0;
            short_q       <= 1'b0;
            long_q        <= 1'b0;
            repeat_q      <= 1'b0;
            press_count_q <= '0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            rep_cnt_q     <= rep_cnt_d;
            press_q       <= press_d;
            release_q     <= release_d;
            short_q       <= short_d;
            long_q        <= long_d;
            repeat_q      <= repeat_d;
            press_count_q <= press_count_d;
        end
    end

    // Next-state logic. A fall always takes priority over the threshold, so
    // a release landing on the threshold cycle is treated as short.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (rise)                    state_d = PRESSED;
            PRESSED:   if (fall)                    state_d = IDLE;
                       else if (hold_cnt_q == HOLD_LAST) state_d = LONG_HELD;
            LONG_HELD: if (fall)                    state_d = IDLE;
            default:                                state_d = IDLE;
        endcase
    end

    // Output and counter logic.
    always_comb begin
        press_d    = 1'b0;
        release_d  = 1'b0;
        short_d    = 1'b0;
        long_d     = 1'b0;
        repeat_d   = 1'b0;
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    press_d    = 1'b1;
                    hold_cnt_d = '0;
                end
            end
            PRESSED: begin
                if (fall) begin
                    short_d   = 1'b1;
                    release_d = 1'b1;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    long_d    = 1'b1;
                    rep_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            LONG_HELD: begin
                if (fall) begin
                    release_d = 1'b1;
                end else if (rep_cnt_q == REP_LAST) begin
                    repeat_d  = 1'b1;
                    rep_cnt_d = '0;
                end else begin
                    rep_cnt_d = rep_cnt_q + REP_W'(1);
                end
            end
            default: ;
        endcase

        if (count_clr) begin
            press_count_d = '0;
        end else if (press_d) begin
            press_count_d = press_count_q + CNT_W'(1);
        end else begin
            press_count_d = press_count_q;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign short_press   = short_q;
    assign long_press    = long_q;
    assign repeat_pulse  = repeat_q;
    assign held          = btn_q;
    assign press_count   = press_count_q;

endmodule

// File: tb/tb_press_classifier.sv
// ---------------------------------------------------------------------------
// tb_press_classifier
// Directed bench for press_classifier with LONG_CYCLES=10, REPEAT_CYCLES=4,
// CNT_W=3. Inputs change on the falling edge, outputs are sampled on the
// falling edge after each rising edge. Edge index j counts rising edges
// from the press edge (j=0); with these parameters long_press is on j=9
// (the 10th held sample) and repeats follow on j=13, 17, 21, ...
// ---------------------------------------------------------------------------
module tb_press_classifier;

    localparam int LC = 10;
    localparam int RC = 4;
    localparam int CW = 3;

    // Hand-derived edge indices for LC=10, RC=4.
    localparam int LONG_AT = 9;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          btn_db    = 1'b0;
    logic          count_clr = 1'b0;
    logic          press_pulse;
    logic          release_pulse;
    logic          short_press;
    logic          long_press;
    logic          repeat_pulse;
    logic          held;
    logic [CW-1:0] press_count;
    logic [4:0]    ev_vec;

    int n_checks = 0;
    int n_fail   = 0;

    press_classifier #(
        .LONG_CYCLES   (LC),
        .REPEAT_CYCLES (RC),
        .CNT_W         (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_db        (btn_db),
        .count_clr     (count_clr),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .short_press   (short_press),
        .long_press    (long_press),
        .repeat_pulse  (repeat_pulse),
        .held          (held),
        .press_count   (press_count)
    );

    always #5 clk = ~clk;

    // {press, release, short, long, repeat}
    assign ev_vec = {press_pulse, release_pulse, short_press, long_press, repeat_pulse};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Hold the button for n samples, release, and check every cycle.
    task automatic press_and_check(input int n, input logic [CW-1:0] cnt_exp);
        logic [4:0] exp;
        for (int j = 0; j <= n; j++) begin
            btn_db = (j < n);
            tick();
            exp = 5'b00000;
            if (j == 0) exp[4] = 1'b1;
            if (j == n) begin
                exp[3] = 1'b1;
                if (n <= LONG_AT) exp[2] = 1'b1;
            end else begin
                if (j == LONG_AT) exp[1] = 1'b1;
                if (j > LONG_AT && ((j - LONG_AT) % RC) == 0) exp[0] = 1'b1;
            end
            check_val($sformatf("ev n=%0d j=%0d", n, j), 32'(ev_vec), 32'(exp));
            check_val($sformatf("held n=%0d j=%0d", n, j), 32'(held), 32'(j < n));
        end
        check_val($sformatf("count n=%0d", n), 32'(press_count), 32'(cnt_exp));
        $display("press hold=%0d count=%0d", n, press_count);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [CW-1:0] wrap_tbl [9];
        wrap_tbl = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst ev", 32'(ev_vec), 32'd0);
        check_val("rst held", 32'(held), 32'd0);
        check_val("rst count", 32'(press_count), 32'd0);
        rst_n = 1'b1;
        tick();
        check_val("idle ev", 32'(ev_vec), 32'd0);
        $display("reset done");

        // Short, long with repeat, threshold race, just-long
        press_and_check(5, 3'd1);
        press_and_check(22, 3'd2);
        press_and_check(9, 3'd3);
        press_and_check(10, 3'd4);

        // Clear, then wrap through 9 presses
        count_clr = 1'b1;
        tick();
        count_clr = 1'b0;
        check_val("clr count", 32'(press_count), 32'd0);
        $display("count_clr count=%0d", press_count);
        for (int i = 0; i < 9; i++) begin
            press_and_check(2, wrap_tbl[i]);
        end

        // Clear coincident with a press: clear wins
        btn_db    = 1'b1;
        count_clr = 1'b1;
        tick();
        count_clr = 1'b0;
        check_val("clr+press ev", 32'(ev_vec), 32'b10000);
        check_val("clr+press count", 32'(press_count), 32'd0);
        btn_db = 1'b0;
        tick();
        check_val("clr+press release", 32'(ev_vec), 32'b01100);
        $display("clear with press count=%0d", press_count);

        // Reset in LONG_HELD with the button still down
        btn_db = 1'b1;
        tick();
        check_val("mid press ev", 32'(ev_vec), 32'b10000);
        check_val("mid press count", 32'(press_count), 32'd1);
        repeat (13) tick();
        check_val("mid repeat ev", 32'(ev_vec), 32'b00001);
        rst_n = 1'b0;
        #1;
        check_val("async rst ev", 32'(ev_vec), 32'd0);
        check_val("async rst held", 32'(held), 32'd0);
        check_val("async rst count", 32'(press_count), 32'd0);
        tick();
        check_val("in rst ev", 32'(ev_vec), 32'd0);
        rst_n = 1'b1;
        tick();
        check_val("post rst ev", 32'(ev_vec), 32'b10000);
        check_val("post rst count", 32'(press_count), 32'd1);
        check_val("post rst held", 32'(held), 32'd1);
        btn_db = 1'b0;
        tick();
        check_val("post rst release", 32'(ev_vec), 32'b01100);
        $display("reset mid-hold count=%0d", press_count);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
